// File: rtl/video_clk_supervisor_pkg.sv
// rtl/video_clk_supervisor_pkg.sv - shared state encoding and constants for the video clock supervisor
package video_clk_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_STABLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    localparam int unsigned PIX_HZ = 33_750_000;
    localparam int unsigned SYS_HZ = 100_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/video_clk_supervisor_sync_ff.sv
// rtl/video_clk_supervisor_sync_ff.sv - 1-bit multi-flop synchronizer, synchronous reset to 0
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/video_clk_supervisor.sv
// rtl/video_clk_supervisor.sv - PLL lock qualification, pixel-rate measurement and video reset control
module video_clk_supervisor
    import video_clk_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int GATE_CYCLES   = 10000,
    parameter int EXP_MIN       = 3340,
    parameter int EXP_MAX       = 3410,
    parameter int FAULT_HOLD    = 4096,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               pix_toggle,
    output logic               video_reset,
    output logic               clk_ok,
    output logic               fault,
    output logic [COUNT_W-1:0] freq_count,
    output logic [7:0]         lock_loss_count
);

    localparam int GATE_W  = $clog2(GATE_CYCLES + 1);
    localparam int TIMER_W = $clog2(max_u(STABLE_CYCLES, FAULT_HOLD) + 1);

    logic locked_s;
    logic pix_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_pix_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pix_toggle),
        .q     (pix_s)
    );

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [COUNT_W-1:0]   freq_q, freq_d;
    logic [7:0]           llc_q, llc_d;
    logic                 pix_dly_q, pix_dly_d;

    logic                 pix_edge;
    logic                 window_active;
    logic                 window_end;
    logic                 in_range;
    logic [COUNT_W-1:0]   edge_base;
    logic [COUNT_W-1:0]   edge_total;

    always_comb begin
        pix_dly_d     = pix_s;
        pix_edge      = pix_s ^ pix_dly_q;
        window_active = (state_q == ST_MEASURE) || (state_q == ST_RUN);
        window_end    = window_active && (gate_q == GATE_W'(GATE_CYCLES - 1));

        // The first cycle of a window restarts the count, but its own edge still counts.
        edge_base  = (gate_q == '0) ? '0 : edge_cnt_q;
        edge_total = (pix_edge && (edge_base != '1)) ? edge_base + 1'b1 : edge_base;
        in_range   = (edge_total >= COUNT_W'(EXP_MIN)) && (edge_total <= COUNT_W'(EXP_MAX));

        state_d    = state_q;
        gate_d     = '0;
        edge_cnt_d = '0;
        freq_d     = freq_q;
        llc_d      = llc_q;
        timer_d    = ((state_q == ST_STABLE) || (state_q == ST_FAULT)) ? timer_q + 1'b1 : '0;

        if (window_active) begin
            edge_cnt_d = edge_total;
            gate_d     = window_end ? '0 : gate_q + 1'b1;
            if (window_end) begin
                freq_d = edge_total;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (locked_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT;
                end else if (timer_q == TIMER_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT;
                end else if (window_end) begin
                    state_d = in_range ? ST_RUN : ST_FAULT;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a simultaneous out-of-range window.
                if (!locked_s) begin
                    state_d = ST_WAIT;
                    if (llc_q != 8'hff) llc_d = llc_q + 8'd1;
                end else if (window_end && !in_range) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (timer_q == TIMER_W'(FAULT_HOLD - 1)) state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT;
            timer_q    <= '0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            llc_q      <= '0;
            pix_dly_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            llc_q      <= llc_d;
            pix_dly_q  <= pix_dly_d;
        end
    end

    assign video_reset     = (state_q != ST_RUN);
    assign clk_ok          = (state_q == ST_RUN);
    assign fault           = (state_q == ST_FAULT);
    assign freq_count      = freq_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_video_clk_supervisor.sv
// tb/tb_video_clk_supervisor.sv - self-checking bench for video_clk_supervisor
module tb_video_clk_supervisor;

    localparam int STABLE = 16;
    localparam int GATE   = 100;
    localparam int EMIN   = 30;
    localparam int EMAX   = 36;
    localparam int HOLD   = 8;

    localparam int M_WAIT = 0, M_STABLE = 1, M_MEASURE = 2, M_RUN = 3, M_FAULT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pll_locked = 1'b0;
    logic        pix_toggle = 1'b0;
    logic        video_reset;
    logic        clk_ok;
    logic        fault;
    logic [15:0] freq_count;
    logic [7:0]  lock_loss_count;

    int checks = 0;
    int errors = 0;
    int pix_period = 0;
    int ph = 0;

    video_clk_supervisor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (STABLE),
        .GATE_CYCLES   (GATE),
        .EXP_MIN       (EMIN),
        .EXP_MAX       (EMAX),
        .FAULT_HOLD    (HOLD),
        .COUNT_W       (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pix_toggle      (pix_toggle),
        .video_reset     (video_reset),
        .clk_ok          (clk_ok),
        .fault           (fault),
        .freq_count      (freq_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pix_period > 0) begin
                ph++;
                if (ph >= pix_period) begin
                    ph = 0;
                    pix_toggle = ~pix_toggle;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs are seen two samples late; an edge is a change between consecutive delayed samples.
    int  m_state = M_WAIT, m_cyc = 0, m_win = 0, m_edges = 0, m_freq = 0, m_llc = 0;
    bit  m_started = 0;
    bit  pl0, pl1, px0, px1, px2;
    bit  lk, ev, ended;

    always @(posedge clk) begin
        if (reset) begin
            m_state = M_WAIT; m_cyc = 0; m_win = 0; m_edges = 0; m_freq = 0; m_llc = 0;
            pl0 = 0; pl1 = 0; px0 = 0; px1 = 0; px2 = 0;
            m_started = 1;
        end else begin
            lk = pl1;
            ev = px1 ^ px2;
            pl1 = pl0; pl0 = pll_locked;
            px2 = px1; px1 = px0; px0 = pix_toggle;
            ended = 0;
            if (m_state == M_MEASURE || m_state == M_RUN) begin
                if (m_win == 0) m_edges = 0;
                if (ev && m_edges < 65535) m_edges++;
                if (m_win == GATE - 1) begin
                    m_freq = m_edges;
                    ended = 1;
                    m_win = 0;
                end else begin
                    m_win++;
                end
            end
            case (m_state)
                M_WAIT: if (lk) begin m_state = M_STABLE; m_cyc = 0; end
                M_STABLE: begin
                    if (!lk) m_state = M_WAIT;
                    else if (m_cyc == STABLE - 1) begin m_state = M_MEASURE; m_win = 0; end
                    else m_cyc++;
                end
                M_MEASURE, M_RUN: begin
                    if (!lk) begin
                        if (m_state == M_RUN && m_llc < 255) m_llc++;
                        m_state = M_WAIT;
                    end else if (ended) begin
                        if (m_freq >= EMIN && m_freq <= EMAX) m_state = M_RUN;
                        else begin m_state = M_FAULT; m_cyc = 0; end
                    end
                end
                default: begin
                    if (m_cyc == HOLD - 1) m_state = M_WAIT;
                    else m_cyc++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("video_reset", int'(video_reset), int'(m_state != M_RUN));
            chk("clk_ok", int'(clk_ok), int'(m_state == M_RUN));
            chk("fault", int'(fault), int'(m_state == M_FAULT));
            chk("freq_count", int'(freq_count), m_freq);
            chk("lock_loss_count", int'(lock_loss_count), m_llc);
        end
    end

    task automatic wait_run(input int maxc, input string name);
        int n = 0;
        while (clk_ok !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
        chk(name, int'(n < maxc), 1);
    endtask

    task automatic wait_fault(input int maxc, input string name);
        int n = 0;
        while (fault !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
        chk(name, int'(n < maxc), 1);
    endtask

    task automatic wait_model(input int st, input int win, input int maxc, input string name);
        int n = 0;
        while (!(m_state == st && (win < 0 || m_win == win)) && n < maxc) begin
            @(negedge clk); n++;
        end
        chk(name, int'(n < maxc), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_video_reset"}, int'(video_reset), 1);
        chk({tag, "_clk_ok"}, int'(clk_ok), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_freq_count"}, int'(freq_count), 0);
        chk({tag, "_lock_loss"}, int'(lock_loss_count), 0);
    endtask

    task automatic drop_lock_one_cycle();
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("init");

        // 1: nominal rate, RUN after 3 sync/decision cycles + 16 stable + 100 window
        @(posedge clk); #1;
        reset = 1'b0; pll_locked = 1'b1; pix_period = 3; ph = 0;
        n = 0;
        @(negedge clk);
        while (clk_ok !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("t1_run_latency", n, 119);
        chk("t1_video_reset", int'(video_reset), 0);
        chk("t1_freq_33_34", int'(freq_count == 33 || freq_count == 34), 1);

        // 2: one-cycle lock drop from RUN
        drop_lock_one_cycle();
        @(negedge clk);
        chk("t2_still_run", int'(clk_ok), 1);
        @(negedge clk);
        chk("t2_video_reset", int'(video_reset), 1);
        chk("t2_lock_loss", int'(lock_loss_count), 1);
        wait_run(400, "t2_relock");

        // 3: too fast -> FAULT held for 8 cycles with a clean 50-edge window
        pix_period = 2; ph = 0;
        wait_fault(500, "t3_first_fault");
        while (fault === 1'b1) @(negedge clk);
        wait_fault(400, "t3_second_fault");
        chk("t3_freq_50", int'(freq_count), 50);
        n = 0;
        while (fault === 1'b1 && n < 20) begin n++; @(negedge clk); end
        chk("t3_fault_len", n, HOLD);

        // 4: stuck toggle, then recovery
        pix_period = 0;
        wait_fault(400, "t4_fault");
        chk("t4_freq_0", int'(freq_count), 0);
        pix_period = 3; ph = 0;
        wait_run(600, "t4_recover");
        chk("t4_freq_33_34", int'(freq_count == 33 || freq_count == 34), 1);

        // 5: lock loss on the exact window-end cycle of an out-of-range window
        wait_model(M_RUN, 5, 300, "t5_win5");
        pix_period = 2; ph = 0;
        wait_model(M_RUN, 97, 300, "t5_win97");
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_still_run", int'(clk_ok), 1);
        @(negedge clk);
        pll_locked = 1'b1;
        chk("t5_not_fault", int'(fault), 0);
        chk("t5_video_reset", int'(video_reset), 1);
        chk("t5_lock_loss", int'(lock_loss_count), 2);
        chk("t5_freq_fast", int'(freq_count >= 45 && freq_count <= 50), 1);
        pix_period = 3; ph = 0;

        // 6: reset mid-MEASURE, then reset in RUN with five lock losses recorded
        wait_model(M_MEASURE, 40, 400, "t6_measure");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t6a");
        reset = 1'b0;
        wait_run(600, "t6_run");
        for (int i = 0; i < 5; i++) begin
            drop_lock_one_cycle();
            repeat (2) @(negedge clk);
            wait_run(600, "t6_relock");
        end
        chk("t6_lock_loss_5", int'(lock_loss_count), 5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t6b");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
